// File: rtl/word_gather.sv
// Serial-in/parallel-out width converter: gathers up to N IN_W-bit words into one OUT_W-bit word.
// Latency: out_valid rises the cycle after the closing accept; sustains one input word per cycle.
// Backpressure: in_ready is high while filling and follows out_ready while a gathered word is held.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     input word handshake; in_data is the word, in_last closes a group early
//   out_valid/out_ready   gathered word handshake; out_data holds word k at [k*IN_W +: IN_W]
//   out_last              group was closed by in_last
//   out_count             number of valid words in out_data (1..N)
module word_gather #(
    parameter int IN_W = 32,
    parameter int N    = 4,
    localparam int OUT_W = IN_W * N,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [CW-1:0]    out_count
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t          state;
    logic [CW-1:0]   idx;

    // While holding, a new word may only enter when the held word leaves in
    // the same cycle, so the next group starts without a bubble.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (state == FILL) ? 1'b1 : out_ready;
        end
    end

    // out_data doubles as the gather buffer; it is zeroed whenever a group
    // leaves so that unfilled slots of a short group always read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        for (int k = 0; k < N; k++) begin
                            if (int'(idx) == k) begin
                                out_data[k*IN_W +: IN_W] <= in_data;
                            end
                        end
                        if (idx == LAST_IDX || in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_count <= idx + ONE;
                            out_last  <= in_last;
                            idx       <= '0;
                        end else begin
                            idx <= idx + ONE;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            // Consume and accept together: the new word seeds slot 0.
                            out_data <= {{(OUT_W-IN_W){1'b0}}, in_data};
                            idx      <= ONE;
                            if (in_last) begin
                                // Single-word group closes immediately; stay in HOLD.
                                out_count <= ONE;
                                out_last  <= 1'b1;
                            end else begin
                                state     <= FILL;
                                out_valid <= 1'b0;
                                out_count <= '0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            state     <= FILL;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_count <= '0;
                            out_last  <= 1'b0;
                            idx       <= '0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
